// File: rtl/bf_graph_loader.sv
// Bellman-Ford graph loader: packs a serial weight stream into LANES-wide rows, writes them, then starts the processing block.
// Optional running checksum of accepted words is added when BF_LOADER_CHECKSUM_EN is defined.
module bf_graph_loader #(
  parameter int LANES  = 32,
  parameter int WIDTH  = 32,
  parameter int ADDR_W = 10,
  parameter int ROWS   = 32
) (
  input  logic                   clk,
  input  logic                   rst_global,
  input  logic                   go,
  input  logic                   abort,
  input  logic [WIDTH-1:0]       in_data,
  input  logic                   in_valid,
  output logic                   in_ready,
  output logic [ADDR_W-1:0]      mem_addr,
  output logic [LANES*WIDTH-1:0] mem_wdata,
  output logic                   mem_we,
  output logic                   mem_sel,
  output logic                   start,
  input  logic                   finish,
  output logic                   busy,
  output logic                   done
`ifdef BF_LOADER_CHECKSUM_EN
  ,
  output logic [WIDTH-1:0]       checksum
`endif
);

  localparam int LW = (LANES > 1) ? $clog2(LANES) : 1;

  typedef enum logic [2:0] {IDLE, LOAD, KICK, RUN, DONE} state_t;

  state_t                 state;
  logic [LW-1:0]          lane_cnt;
  logic [ADDR_W-1:0]      row_cnt;
  logic [LANES*WIDTH-1:0] row_reg;
  logic [LANES*WIDTH-1:0] row_next;
  logic                   accept;
  logic                   row_full;
  logic                   last_row;

  assign in_ready = (state == LOAD);
  assign accept   = in_ready && in_valid;
  assign row_full = (lane_cnt == LW'(LANES - 1));
  assign last_row = (row_cnt == ADDR_W'(ROWS - 1));

  // NOTE: give every always_comb output a default first so no path can infer a latch.
  always_comb begin
    row_next = row_reg;
    row_next[lane_cnt*WIDTH +: WIDTH] = in_data;
  end

  // NOTE: registered state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst_global) begin
    if (rst_global) begin
      state     <= IDLE;
      lane_cnt  <= '0;
      row_cnt   <= '0;
      // NOTE: row_reg is plain flops rather than a RAM, so it takes the async reset too.
      row_reg   <= '0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      mem_we    <= 1'b0;
      mem_sel   <= 1'b0;
      start     <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      mem_we <= 1'b0;
      start  <= 1'b0;
      done   <= 1'b0;
      case (state)
        IDLE: begin
          lane_cnt <= '0;
          row_cnt  <= '0;
          if (go) begin
            state   <= LOAD;
            busy    <= 1'b1;
            mem_sel <= 1'b1;
          end
        end
        LOAD: begin
          if (abort) begin
            state    <= IDLE;
            busy     <= 1'b0;
            mem_sel  <= 1'b0;
            lane_cnt <= '0;
            row_cnt  <= '0;
          end else if (accept) begin
            row_reg <= row_next;
            if (row_full) begin
              // Memory samples the completed row next cycle, so lane 0 of the next row can land now.
              mem_we    <= 1'b1;
              mem_addr  <= row_cnt;
              mem_wdata <= row_next;
              lane_cnt  <= '0;
              row_cnt   <= row_cnt + 1'b1;
              if (last_row) state <= KICK;
            end else begin
              lane_cnt <= lane_cnt + 1'b1;
            end
          end
        end
        KICK: begin
          mem_sel <= 1'b0;
          start   <= 1'b1;
          state   <= RUN;
        end
        RUN: begin
          if (finish) begin
            done  <= 1'b1;
            state <= DONE;
          end
        end
        DONE: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef BF_LOADER_CHECKSUM_EN
  always_ff @(posedge clk or posedge rst_global) begin
    if (rst_global) begin
      checksum <= '0;
    end else if ((state == IDLE && go) || (state == LOAD && abort)) begin
      checksum <= '0;
    end else if (accept) begin
      checksum <= checksum + in_data;
    end
  end
`endif

endmodule

// File: tb/tb_bf_graph_loader.sv
// Self-checking bench for bf_graph_loader: event-level model compared every cycle, plus literal timing/image checks.
module tb_bf_graph_loader;

  localparam int LANES  = 32;
  localparam int WIDTH  = 32;
  localparam int ADDR_W = 10;
  localparam int ROWS   = 32;
  localparam int NWORDS = LANES * ROWS;

  logic                   clk = 1'b0;
  logic                   rst = 1'b0;
  logic                   go = 1'b0;
  logic                   abort = 1'b0;
  logic                   in_valid = 1'b0;
  logic                   finish = 1'b0;
  logic [WIDTH-1:0]       in_data = '0;
  logic                   in_ready;
  logic [ADDR_W-1:0]      mem_addr;
  logic [LANES*WIDTH-1:0] mem_wdata;
  logic                   mem_we;
  logic                   mem_sel;
  logic                   start;
  logic                   busy;
  logic                   done;
`ifdef BF_LOADER_CHECKSUM_EN
  logic [WIDTH-1:0]       checksum;
`endif

  bf_graph_loader #(.LANES(LANES), .WIDTH(WIDTH), .ADDR_W(ADDR_W), .ROWS(ROWS)) dut (
    .clk(clk), .rst_global(rst), .go(go), .abort(abort),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we), .mem_sel(mem_sel),
    .start(start), .finish(finish), .busy(busy), .done(done)
`ifdef BF_LOADER_CHECKSUM_EN
    , .checksum(checksum)
`endif
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic check_row(input logic [LANES*WIDTH-1:0] act, input logic [LANES*WIDTH-1:0] exp);
    int bad;
    bad = -1;
    n_checks++;
    for (int i = LANES - 1; i >= 0; i--)
      if (act[i*WIDTH +: WIDTH] !== exp[i*WIDTH +: WIDTH]) bad = i;
    if (bad >= 0) begin
      n_err++;
      $display("FAIL mem_wdata lane %0d: got %0h expected %0h", bad,
               act[bad*WIDTH +: WIDTH], exp[bad*WIDTH +: WIDTH]);
    end
  endtask

  // ---------------- behavioural model (word queue + pending events) ----------------
  int                     ec = 0;
  bit                     m_load, m_kick, m_run, m_in_done;
  int                     m_row, m_acc, m_go_ec, m_last_acc_ec;
  logic [WIDTH-1:0]       m_buf[$];
  logic [WIDTH-1:0]       m_sum;
  logic                   e_we, e_start, e_done, e_sel, e_ready, e_busy;
  logic [ADDR_W-1:0]      e_addr;
  logic [LANES*WIDTH-1:0] e_wdata;
  bit                     data_ones = 1'b0;

  task automatic model_reset();
    m_load = 0; m_kick = 0; m_run = 0; m_in_done = 0;
    m_row = 0; m_acc = 0; m_buf.delete(); m_sum = '0;
    e_we = 0; e_start = 0; e_done = 0; e_sel = 0; e_ready = 0; e_busy = 0;
    e_addr = '0; e_wdata = '0;
  endtask

  task automatic model_step();
    bit was_kick, was_run, was_done;
    was_kick = m_kick; was_run = m_run; was_done = m_in_done;
    e_we = 0; e_start = 0; e_done = 0; m_in_done = 0;
    if (was_run && finish) begin
      m_run = 0; e_done = 1; m_in_done = 1;
    end
    if (was_kick) begin
      m_kick = 0; e_start = 1; m_run = 1;
    end
    if (m_load) begin
      if (abort) begin
        m_load = 0; m_buf.delete(); m_row = 0; m_acc = 0; m_sum = '0;
      end else if (in_valid) begin
        m_buf.push_back(in_data);
        m_acc++;
        m_sum = m_sum + in_data;
        m_last_acc_ec = ec;
        if (m_buf.size() == LANES) begin
          e_we = 1;
          e_addr = ADDR_W'(m_row);
          for (int i = 0; i < LANES; i++) e_wdata[i*WIDTH +: WIDTH] = m_buf[i];
          m_buf.delete();
          m_row++;
          if (m_row == ROWS) begin
            m_load = 0; m_kick = 1;
          end
        end
      end
    end else if (!was_kick && !was_run && !was_done && go) begin
      m_load = 1; m_row = 0; m_acc = 0; m_buf.delete(); m_sum = '0; m_go_ec = ec;
    end
    e_ready = m_load;
    e_sel   = m_load || e_we;
    e_busy  = m_load || m_kick || m_run || m_in_done;
  endtask

  initial begin
    model_reset();
    m_go_ec = -1;
    forever begin
      @(posedge clk or posedge rst);
      if (rst) model_reset();
      else begin
        ec++;
        model_step();
      end
    end
  end

  always @(negedge clk) in_data = data_ones ? '1 : WIDTH'(m_acc);

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    check("in_ready", in_ready, e_ready);
    check("mem_we", mem_we, e_we);
    check("mem_sel", mem_sel, e_sel);
    check("start", start, e_start);
    check("busy", busy, e_busy);
    check("done", done, e_done);
    if (e_we) begin
      check("mem_addr", mem_addr, e_addr);
      check_row(mem_wdata, e_wdata);
    end
`ifdef BF_LOADER_CHECKSUM_EN
    check("checksum", checksum, m_sum);
`endif
  end

  // ---------------- observation of DUT events for literal checks ----------------
  int               n_we, first_we_cyc, last_we_cyc, start_cyc, done_cyc, ready_low_cyc;
  logic [WIDTH-1:0] dut_img[ROWS][LANES];
  logic [WIDTH-1:0] sum_at_start;

  always @(negedge clk) begin
    int cyc;
    if (!rst && m_go_ec >= 0) begin
      cyc = ec - m_go_ec + 1;
      if (mem_we) begin
        n_we++;
        if (first_we_cyc < 0) first_we_cyc = cyc;
        last_we_cyc = cyc;
        if (int'(mem_addr) < ROWS)
          for (int i = 0; i < LANES; i++) dut_img[mem_addr][i] = mem_wdata[i*WIDTH +: WIDTH];
      end
      if (start && start_cyc < 0) begin
        start_cyc = cyc;
`ifdef BF_LOADER_CHECKSUM_EN
        sum_at_start = checksum;
`else
        sum_at_start = '0;
`endif
      end
      if (done && done_cyc < 0) done_cyc = cyc;
      if (!in_ready && ready_low_cyc < 0) ready_low_cyc = cyc;
    end
  end

  task automatic clear_obs();
    n_we = 0; first_we_cyc = -1; last_we_cyc = -1; start_cyc = -1; done_cyc = -1;
    ready_low_cyc = -1; m_go_ec = -1;
    for (int r = 0; r < ROWS; r++)
      for (int i = 0; i < LANES; i++) dut_img[r][i] = 32'hDEAD_BEEF;
  endtask

  task automatic timeout(input string name);
    n_checks++;
    n_err++;
    $display("FAIL %s: timed out waiting, got none expected event", name);
  endtask

  // ---------------- stimulus tasks (entered and left on a negedge) ----------------
  task automatic feed(input int n, input bit rnd, input int budget);
    int t;
    t = 0;
    while (m_acc < n && m_load && t < budget) begin
      in_valid = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      @(negedge clk);
      t++;
    end
    in_valid = 1'b0;
    if (t >= budget) timeout("feed");
  endtask

  task automatic handshake(input bit extra_go);
    int t;
    t = 0;
    while (!start && t < 200) begin
      @(negedge clk);
      t++;
    end
    if (!start) timeout("start");
    for (int k = 0; k < 10; k++) begin
      go = (extra_go && k == 3);
      @(negedge clk);
    end
    go = 1'b0;
    finish = 1'b1;
    t = 0;
    while (!done && t < 50) begin
      @(negedge clk);
      t++;
    end
    if (!done) timeout("done");
    finish = 1'b0;
    repeat (2) @(negedge clk);
    check("done_after_finish", 64'(done_cyc - start_cyc), 64'd11);
    check("busy_after_done", busy, 1'b0);
  endtask

  task automatic do_load(input bit rnd, input bit ones, input bit extra_go);
    clear_obs();
    data_ones = ones;
    go = 1'b1;
    @(negedge clk);
    go = 1'b0;
    feed(NWORDS, rnd, 4 * NWORDS);
    handshake(extra_go);
  endtask

  task automatic check_image(input string tag);
    int bad;
    bad = 0;
    for (int r = 0; r < ROWS; r++)
      for (int i = 0; i < LANES; i++)
        if (dut_img[r][i] !== WIDTH'(r * LANES + i)) bad++;
    check({tag, "_image_bad_words"}, 64'(bad), 64'd0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_in_ready"}, in_ready, 1'b0);
    check({tag, "_mem_we"}, mem_we, 1'b0);
    check({tag, "_mem_addr"}, mem_addr, '0);
    check({tag, "_mem_wdata_nonzero"}, 64'(|mem_wdata), 64'd0);
    check({tag, "_mem_sel"}, mem_sel, 1'b0);
    check({tag, "_start"}, start, 1'b0);
    check({tag, "_busy"}, busy, 1'b0);
    check({tag, "_done"}, done, 1'b0);
`ifdef BF_LOADER_CHECKSUM_EN
    check({tag, "_checksum"}, checksum, '0);
`endif
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation still running, expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    clear_obs();
    #1 rst = 1'b1;
    #30;
    check_reset_outputs("reset");
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // Full load with in_valid held high, plus a stray go while RUN.
    do_load(1'b0, 1'b0, 1'b1);
    check("full_start_cycle", 64'(start_cyc), 64'd1026);
    check("full_first_we_cycle", 64'(first_we_cyc), 64'd33);
    check("full_last_we_cycle", 64'(last_we_cyc), 64'd1025);
    check("full_we_count", 64'(n_we), 64'd32);
    check("full_ready_low_cycle", 64'(ready_low_cyc), 64'd1025);
    check("full_row0_lane0", dut_img[0][0], 32'd0);
    check("full_row3_lane5", dut_img[3][5], 32'd101);
    check("full_row31_lane31", dut_img[31][31], 32'd1023);
    check_image("full");

    // Abort after word 40, raised together with a valid word.
    clear_obs();
    go = 1'b1;
    @(negedge clk);
    go = 1'b0;
    feed(40, 1'b0, 200);
    in_valid = 1'b1;
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    in_valid = 1'b0;
    repeat (5) @(negedge clk);
    check("abort40_we_count", 64'(n_we), 64'd1);
    check("abort40_row0_lane31", dut_img[0][31], 32'd31);
    check("abort40_no_start", 64'(start_cyc), 64'hFFFF_FFFF_FFFF_FFFF);
    check("abort40_busy", busy, 1'b0);

    // Abort coinciding with the word that would complete row 1.
    clear_obs();
    go = 1'b1;
    @(negedge clk);
    go = 1'b0;
    feed(63, 1'b0, 200);
    in_valid = 1'b1;
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    in_valid = 1'b0;
    repeat (5) @(negedge clk);
    check("abort64_we_count", 64'(n_we), 64'd1);
    check("abort64_no_start", 64'(start_cyc), 64'hFFFF_FFFF_FFFF_FFFF);

    // Backpressure: random gaps, reload starts again from row 0 lane 0.
    do_load(1'b1, 1'b0, 1'b0);
    check("bp_we_count", 64'(n_we), 64'd32);
    check("bp_start_after_last_word", 64'(start_cyc - (m_last_acc_ec - m_go_ec)), 64'd2);
    check_image("bp");

    // Reset mid-load at word 500, then a clean full load.
    clear_obs();
    go = 1'b1;
    @(negedge clk);
    go = 1'b0;
    feed(500, 1'b0, 1000);
    #1 rst = 1'b1;
    #1;
    check_reset_outputs("midreset");
    @(negedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    do_load(1'b0, 1'b0, 1'b0);
    check("postreset_start_cycle", 64'(start_cyc), 64'd1026);
    check_image("postreset");

`ifdef BF_LOADER_CHECKSUM_EN
    do_load(1'b0, 1'b1, 1'b0);
    check("checksum_at_start", sum_at_start, 32'hFFFF_FC00);
    check("checksum_held", checksum, 32'hFFFF_FC00);
`endif

    $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
    $finish;
  end

endmodule
